// File: rtl/mesh_loader_if.sv
// Host word stream into the mesh loader: 32-bit words with a valid/ready handshake.
interface mesh_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mesh_loader.sv
// Streams a host mesh image into RAM0, validates counts and indices, zeroes the
// RAM2 edge map, then launches subdiv and waits for it to finish.
module mesh_loader #(
  parameter int RAM_WORDS = 2048
) (
  input  logic         clk,
  input  logic         rst_n,
  mesh_loader_if.slave host,
  output logic         RAM0_EN,
  output logic [10:0]  RAM0_A,
  output logic [3:0]   RAM0_WE,
  output logic [31:0]  RAM0_Di,
  output logic         RAM2_EN,
  output logic [10:0]  RAM2_A,
  output logic [3:0]   RAM2_WE,
  output logic [31:0]  RAM2_Di,
  output logic         sub_start,
  input  logic         sub_busy,
  output logic         done,
  output logic         error,
  output logic [2:0]   err_code,
  input  logic         err_clr
);
  localparam logic [2:0]  ERR_CNT     = 3'd1;
  localparam logic [2:0]  ERR_IN_CAP  = 3'd2;
  localparam logic [2:0]  ERR_OUT_CAP = 3'd3;
  localparam logic [2:0]  ERR_IDX     = 3'd4;
  localparam logic [31:0] CAP         = 32'(RAM_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_VERTS, S_FCNT, S_FACES, S_CLEAR, S_START, S_WAIT_HI, S_WAIT_LO, S_ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [10:0] v_reg, v_next, f_reg, f_next, addr_reg, addr_next;
  logic [10:0] clr_reg, clr_next, clr_last_reg, clr_last_next;
  logic [12:0] cnt_reg, cnt_next;
  logic [10:0] ram0_a_reg, ram0_a_next, ram2_a_reg, ram2_a_next;
  logic [31:0] ram0_di_reg, ram0_di_next;
  logic        ram0_wr_reg, ram0_wr_next, ram2_wr_reg, ram2_wr_next;
  logic        sub_start_reg, sub_start_next, done_reg, done_next;
  logic [2:0]  err_code_reg, err_code_next;

  logic        accept;
  logic [31:0] d, v32, f32, tri_d, words_v, words_in, words_out, clr_last_w;

  assign d          = host.in_data;
  assign v32        = {21'd0, v_reg};
  assign f32        = {21'd0, f_reg};
  assign tri_d      = 32'd3 * d;
  assign words_v    = tri_d + 32'd2;
  assign words_in   = 32'd3 * v32 + tri_d + 32'd2;
  assign words_out  = 32'd6 * v32 + 32'd15 * d - 32'd4;
  // Last RAM2 word to zero is 3E+2 with E = V+F-2.
  assign clr_last_w = 32'd3 * v32 + 32'd3 * f32 - 32'd4;

  assign host.in_ready = (state_reg == S_IDLE) || (state_reg == S_VERTS) ||
                         (state_reg == S_FCNT) || (state_reg == S_FACES);
  assign accept    = host.in_valid && host.in_ready;

  assign RAM0_EN   = 1'b1;
  assign RAM2_EN   = 1'b1;
  assign RAM0_A    = ram0_a_reg;
  assign RAM0_WE   = {4{ram0_wr_reg}};
  assign RAM0_Di   = ram0_di_reg;
  assign RAM2_A    = ram2_a_reg;
  assign RAM2_WE   = {4{ram2_wr_reg}};
  assign RAM2_Di   = 32'd0;
  assign sub_start = sub_start_reg;
  assign done      = done_reg;
  assign error     = (state_reg == S_ERR);
  assign err_code  = err_code_reg;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      v_reg         <= '0;
      f_reg         <= '0;
      addr_reg      <= '0;
      clr_reg       <= '0;
      clr_last_reg  <= '0;
      cnt_reg       <= '0;
      ram0_a_reg    <= '0;
      ram0_di_reg   <= '0;
      ram0_wr_reg   <= 1'b0;
      ram2_a_reg    <= '0;
      ram2_wr_reg   <= 1'b0;
      sub_start_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_code_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      v_reg         <= v_next;
      f_reg         <= f_next;
      addr_reg      <= addr_next;
      clr_reg       <= clr_next;
      clr_last_reg  <= clr_last_next;
      cnt_reg       <= cnt_next;
      ram0_a_reg    <= ram0_a_next;
      ram0_di_reg   <= ram0_di_next;
      ram0_wr_reg   <= ram0_wr_next;
      ram2_a_reg    <= ram2_a_next;
      ram2_wr_reg   <= ram2_wr_next;
      sub_start_reg <= sub_start_next;
      done_reg      <= done_next;
      err_code_reg  <= err_code_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    v_next         = v_reg;
    f_next         = f_reg;
    addr_next      = addr_reg;
    clr_next       = clr_reg;
    clr_last_next  = clr_last_reg;
    cnt_next       = cnt_reg;
    ram0_a_next    = ram0_a_reg;
    ram0_di_next   = ram0_di_reg;
    ram0_wr_next   = 1'b0;
    ram2_a_next    = ram2_a_reg;
    ram2_wr_next   = 1'b0;
    sub_start_next = 1'b0;
    done_next      = 1'b0;
    err_code_next  = err_code_reg;

    // Every accepted word lands in RAM0, including one that trips an error.
    if (accept) begin
      ram0_wr_next = 1'b1;
      ram0_a_next  = addr_reg;
      ram0_di_next = d;
      addr_next    = addr_reg + 11'd1;
    end

    case (state_reg)
      S_IDLE: if (accept) begin
        ram0_a_next = 11'd0;
        addr_next   = 11'd1;
        v_next      = d[10:0];
        cnt_next    = tri_d[12:0];
        if (d < 32'd3) begin
          err_code_next = ERR_CNT;
          state_next    = S_ERR;
        end else if (d[31:11] != 21'd0 || words_v > CAP) begin
          err_code_next = ERR_IN_CAP;
          state_next    = S_ERR;
        end else begin
          state_next = S_VERTS;
        end
      end
      S_VERTS: if (accept) begin
        cnt_next = cnt_reg - 13'd1;
        if (cnt_reg == 13'd1) state_next = S_FCNT;
      end
      S_FCNT: if (accept) begin
        f_next   = d[10:0];
        cnt_next = tri_d[12:0];
        if (d == 32'd0 || d[31:11] != 21'd0) begin
          err_code_next = ERR_CNT;
          state_next    = S_ERR;
        end else if (words_in > CAP) begin
          err_code_next = ERR_IN_CAP;
          state_next    = S_ERR;
        end else if (words_out > CAP) begin
          err_code_next = ERR_OUT_CAP;
          state_next    = S_ERR;
        end else begin
          state_next = S_FACES;
        end
      end
      S_FACES: if (accept) begin
        cnt_next = cnt_reg - 13'd1;
        if (d == 32'd0 || d > v32) begin
          err_code_next = ERR_IDX;
          state_next    = S_ERR;
        end else if (cnt_reg == 13'd1) begin
          clr_next      = 11'd0;
          clr_last_next = clr_last_w[10:0];
          state_next    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ram2_wr_next = 1'b1;
        ram2_a_next  = clr_reg;
        clr_next     = clr_reg + 11'd1;
        if (clr_reg == clr_last_reg) state_next = S_START;
      end
      S_START: begin
        ram0_a_next    = 11'd0;
        ram2_a_next    = 11'd0;
        sub_start_next = 1'b1;
        state_next     = S_WAIT_HI;
      end
      S_WAIT_HI: if (sub_busy) state_next = S_WAIT_LO;
      S_WAIT_LO: if (!sub_busy) begin
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      S_ERR: if (err_clr) begin
        err_code_next = 3'd0;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mesh_loader.sv
// Self-checking bench for mesh_loader: stream-level model of the RAM0 image,
// RAM2 clear, subdiv handshake and error rules, compared every cycle.
module tb_mesh_loader;
  logic        clk, rst_n, sub_busy, err_clr;
  logic        RAM0_EN, RAM2_EN, sub_start, done, error;
  logic [10:0] RAM0_A, RAM2_A;
  logic [3:0]  RAM0_WE, RAM2_WE;
  logic [31:0] RAM0_Di, RAM2_Di;
  logic [2:0]  err_code;

  mesh_loader_if host();

  mesh_loader #(.RAM_WORDS(2048)) dut (
    .clk(clk), .rst_n(rst_n), .host(host),
    .RAM0_EN(RAM0_EN), .RAM0_A(RAM0_A), .RAM0_WE(RAM0_WE), .RAM0_Di(RAM0_Di),
    .RAM2_EN(RAM2_EN), .RAM2_A(RAM2_A), .RAM2_WE(RAM2_WE), .RAM2_Di(RAM2_Di),
    .sub_start(sub_start), .sub_busy(sub_busy), .done(done),
    .error(error), .err_code(err_code), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [10:0] a; logic [31:0] d; } wr_t;

  int          checks = 0, failures = 0, cyc = 0;
  wr_t         exp0[$], exp2[$];
  int          start_due = -1, done_due = -1, busy_left = 0;
  bit          chk_en = 1'b0;
  bit          m_ready = 1'b1, m_error = 1'b0;
  logic [2:0]  m_code = 3'd0;
  logic [31:0] ram0_img [0:2047];
  int          ram2_writes = 0, start_pulses = 0, done_pulses = 0;
  logic [31:0] tet[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, plus a simple subdiv stand-in.
  always @(posedge clk) begin
    cyc++;
    if (chk_en) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          sub_busy = 1'b0;
          done_due = cyc + 1;
        end
      end
      if (cyc == done_due) m_ready = 1'b1;
      check("ram0_en", RAM0_EN, 1);
      check("ram2_en", RAM2_EN, 1);
      check("ram2_di", RAM2_Di, 0);
      if (exp0.size() > 0 && exp0[0].due == cyc) begin
        check("ram0_we", RAM0_WE, 4'hF);
        check("ram0_a", RAM0_A, exp0[0].a);
        check("ram0_di", RAM0_Di, exp0[0].d);
        void'(exp0.pop_front());
      end else check("ram0_we_idle", RAM0_WE, 0);
      if (exp2.size() > 0 && exp2[0].due == cyc) begin
        check("ram2_we", RAM2_WE, 4'hF);
        check("ram2_a", RAM2_A, exp2[0].a);
        void'(exp2.pop_front());
      end else check("ram2_we_idle", RAM2_WE, 0);
      if (RAM0_WE == 4'hF) ram0_img[RAM0_A] = RAM0_Di;
      if (RAM2_WE == 4'hF) ram2_writes++;
      check("sub_start", sub_start, cyc == start_due);
      if (cyc == start_due) begin
        check("ram0_a_release", RAM0_A, 0);
        check("ram2_a_release", RAM2_A, 0);
      end
      if (sub_start) begin
        start_pulses++;
        sub_busy  = 1'b1;
        busy_left = 50;
      end
      check("done", done, cyc == done_due);
      if (done) done_pulses++;
      check("in_ready", host.in_ready, m_ready);
      check("error", error, m_error);
      check("err_code", err_code, m_code);
    end
  end

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps and err_clr noise
  task automatic send(input logic [31:0] w[$], input int mode, input int stop_after);
    int k = 0, it = 0, code;
    longint vv = 0, ff = 0, x;
    bit err = 1'b0;
    wr_t e;
    while (k < w.size() && k < stop_after && !err && it < 20000) begin
      @(posedge clk); #1;
      it++;
      case (mode)
        0:       host.in_valid = 1'b1;
        1:       host.in_valid = (it % 2 == 0);
        default: host.in_valid = ($urandom_range(0, 3) != 0);
      endcase
      err_clr = (mode == 2) && ($urandom_range(0, 7) == 0);
      host.in_data = host.in_valid ? w[k] : $urandom;
      if (host.in_valid && host.in_ready) begin
        x = longint'(w[k]);
        code = 0;
        if (k == 0) begin
          vv = x;
          if (x < 3) code = 1;
          else if (x >= 2048 || 3 * x + 2 > 2048) code = 2;
        end else if (k == 3 * vv + 1) begin
          ff = x;
          if (x == 0 || x >= 2048) code = 1;
          else if (3 * vv + 3 * ff + 2 > 2048) code = 2;
          else if (6 * vv + 15 * ff - 4 > 2048) code = 3;
        end else if (k > 3 * vv + 1) begin
          if (x == 0 || x > vv) code = 4;
        end
        e.due = cyc + 1; e.a = 11'(k); e.d = w[k];
        exp0.push_back(e);
        if (code != 0) begin
          m_error = 1'b1; m_code = 3'(code); m_ready = 1'b0; err = 1'b1;
        end else if (k > 3 * vv + 1 && k == 3 * vv + 3 * ff + 1) begin
          for (int i = 0; i < 3 * (vv + ff - 2) + 3; i++) begin
            e.due = cyc + 2 + i; e.a = 11'(i); e.d = 32'd0;
            exp2.push_back(e);
          end
          start_due = cyc + 2 + int'(3 * (vv + ff - 2) + 3);
          m_ready = 1'b0;
        end
        k++;
      end
    end
    @(posedge clk); #1;
    host.in_valid = 1'b0;
    err_clr = 1'b0;
    checks++;
    if (it >= 20000) begin
      failures++;
      $display("FAIL send_timeout: got %0d words expected %0d", k, stop_after);
    end
    $display("stream mode=%0d accepted=%0d words error_code=%0d", mode, k, m_code);
  endtask

  task automatic wait_done();
    int d0 = done_pulses, t = 0;
    while (done_pulses == d0 && t < 400) begin @(posedge clk); #1; t++; end
    check("done_seen", done_pulses - d0, 1);
  endtask

  task automatic clear_err();
    @(posedge clk); #1;
    err_clr = 1'b1;
    m_error = 1'b0; m_code = 3'd0; m_ready = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", host.in_ready, 1);
    check("rst_ram0_en", RAM0_EN, 1);
    check("rst_ram2_en", RAM2_EN, 1);
    check("rst_ram0_we", RAM0_WE, 0);
    check("rst_ram2_we", RAM2_WE, 0);
    check("rst_ram0_a", RAM0_A, 0);
    check("rst_ram2_a", RAM2_A, 0);
    check("rst_ram0_di", RAM0_Di, 0);
    check("rst_sub_start", sub_start, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
  endtask

  task automatic run_tetra(input int mode, input string tag);
    int r0 = ram2_writes, s0 = start_pulses;
    for (int i = 0; i < 26; i++) ram0_img[i] = 32'hDEADBEEF;
    send(tet, mode, 1000);
    wait_done();
    check("ram0_v", ram0_img[0], 32'd4);
    check("ram0_f", ram0_img[13], 32'd4);
    check("ram0_face_first", ram0_img[14], 32'd1);
    check("ram0_face_last", ram0_img[25], 32'd3);
    for (int i = 0; i < 26; i++) check("ram0_image", ram0_img[i], tet[i]);
    check("ram2_clear_count", ram2_writes - r0, 21);
    check("start_pulses", start_pulses - s0, 1);
    check("ready_after_done", host.in_ready, 1);
    $display("load %s complete", tag);
  endtask

  task automatic error_case(input logic [31:0] w[$], input logic [2:0] code, input string tag);
    send(w, 2, 100000);
    repeat (3) @(posedge clk);
    #1;
    check("err_flag", error, 1);
    check("err_code_lit", err_code, code);
    check("err_ready", host.in_ready, 0);
    clear_err();
    check("clr_code", err_code, 0);
    check("clr_ready", host.in_ready, 1);
    $display("error case %s cleared", tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    tet = {32'd4,
           32'd1, 32'd1, 32'd1,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
           32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
           32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'd4,
           32'd1, 32'd2, 32'd3, 32'd1, 32'd4, 32'd2,
           32'd1, 32'd3, 32'd4, 32'd2, 32'd4, 32'd3};
    rst_n = 1'b0; sub_busy = 1'b0; err_clr = 1'b0;
    host.in_valid = 1'b0; host.in_data = 32'd0;
    #3;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1; chk_en = 1'b1;

    run_tetra(0, "tetra back-to-back");
    run_tetra(1, "tetra toggled valid");

    w = tet;
    w[18] = 32'd5;
    error_case(w, 3'd4, "bad face index");

    w = {32'd300};
    for (int i = 0; i < 900; i++) w.push_back($urandom);
    w.push_back(32'd100);
    error_case(w, 3'd3, "output capacity");
    w = {32'd2};
    error_case(w, 3'd1, "vertex count");
    w = {32'd700};
    error_case(w, 3'd2, "input capacity");

    send(tet, 0, 21);
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp0.delete(); exp2.delete();
    start_due = -1; done_due = -1; busy_left = 0; sub_busy = 1'b0;
    m_ready = 1'b1; m_error = 1'b0; m_code = 3'd0;
    $display("reset asserted during faces");
    @(posedge clk); #2;
    rst_n = 1'b1; chk_en = 1'b1;

    run_tetra(0, "tetra after reset");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mesh_loader.md
Name: mesh_loader

Overview:
- Upstream stage of the subdivision engine. Accepts a host word stream (valid/ready) and writes the input mesh image into RAM0 in the layout subdiv consumes.
- Validates counts, capacities and face indices, zeroes the RAM2 edge-map region, then pulses subdiv start and waits for it to finish.
- Owns the RAM0/RAM2 port signals while busy; top-level muxing hands those ports to subdiv whenever sub_busy=1.

Parameters:
- RAM_WORDS, 2048, words per RAM macro; addresses are 11 bits.

Ports:
- clk  in  1  system clock; all state updates on negedge clk, matching subdiv's RAM timing.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  host word valid.
- in_data  in  32  host word.
- in_ready  out  1  loader can accept a word.
- RAM0_EN, RAM2_EN  out  1  RAM enables.
- RAM0_A, RAM2_A  out  11  RAM addresses.
- RAM0_WE, RAM2_WE  out  4  byte write enables.
- RAM0_Di, RAM2_Di  out  32  RAM write data.
- sub_start  out  1  one-cycle start pulse to subdiv.
- sub_busy  in  1  subdiv busy flag.
- done  out  1  one-cycle pulse when subdiv completes.
- error  out  1  sticky error flag.
- err_code  out  3  0 none, 1 CNT, 2 IN_CAP, 3 OUT_CAP, 4 IDX.
- err_clr  in  1  clears error and returns the block to IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; RAM*_EN=1; RAM*_WE=0; RAM*_A=0; RAM*_Di=0.
  - sub_start=0, done=0, error=0, err_code=0; internal V, F, address and face counters cleared.
- Stream format, one word accepted when in_valid&&in_ready at the active edge:
  - V, then 3V vertex words (x,y,z signed), then F, then 3F face indices (1-based).
- RAM0 image:
  - word 0 = V; words 1..3V = vertices; word 3V+1 = F; words 3V+2.. = faces.
  - Each accepted word is registered to RAM0_A/Di with RAM0_WE=4'hF on the same edge. With no accept, WE=0.
- IDLE/VCNT: accept V, write addr 0. Errors:
  - V<3 -> CNT.
  - V[31:11]!=0 or 3V+2>RAM_WORDS -> IN_CAP.
- VERTS: accept 3V words at addr 1..3V, then go to FCNT.
- FCNT: accept F, write addr 3V+1. Errors, checked in this priority order:
  - F==0 or F[31:11]!=0 -> CNT.
  - 3V+3F+2>RAM_WORDS -> IN_CAP.
  - 6V+15F-4>RAM_WORDS -> OUT_CAP (output-mesh size in RAM1).
  - Compute in 32 bits after bounding.
- FACES: accept 3F words at addr 3V+2 onward.
  - Any index 0 or >V -> IDX. The offending word is still written.
  - After the last word, compute E=V+F-2 and go to CLEAR.
- CLEAR:
  - in_ready=0. Write 0 to RAM2 words 0..3E+2, one per cycle, ascending, RAM2_WE=4'hF. Then WE=0 and RAM2_A=0.
- START: sub_start=1 for exactly one cycle; release RAM0/RAM2 drive (WE=0, A=0).
- WAIT_HI: wait for sub_busy=1.
- WAIT_LO: wait for sub_busy=0, then done=1 for one cycle and return to IDLE with in_ready=1.
- ERR:
  - Entered on the edge the bad word is accepted. in_ready=0, error=1, err_code held, no further RAM writes.
  - Leaves only on err_clr=1, which clears error/err_code and goes to IDLE. err_clr is ignored outside ERR.
- in_ready: 1 only in IDLE/VERTS/FCNT/FACES.
- Backpressure: in_valid may drop at any time. No state advance and no write on idle cycles.
- Reset mid-load or mid-WAIT aborts immediately to IDLE; RAM contents are undefined. Top-level resets subdiv concurrently.
- Latency: RAM write one edge after accept. sub_start asserted the cycle after the last clear write.

Test Plan:
- Tetrahedron V=4, F=4, 26 words streamed back-to-back:
  - RAM0[0]=4, RAM0[13]=4, faces at 14..25.
  - RAM2[0..20] zeroed (21 writes).
  - One sub_start pulse; model sub_busy high for 50 cycles -> one done pulse, in_ready=1.
- Same mesh with in_valid toggled every other cycle -> identical RAM0 image, no spurious writes.
- Tetrahedron, 5th face word =5 -> error=1, err_code=4, in_ready=0; err_clr -> IDLE, err_code=0.
- V=300 accepted, then F=100 -> 6*300+1500-4=3296>2048, err_code=3 on the F word; V=2 -> err_code=1; V=700 -> err_code=2.
- rst_n low during FACES at word 20 -> all outputs at reset values asynchronously. Reload of the full tetrahedron then completes normally.
